// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: latches a value on a load strobe and shows
// it in hex, or in decimal after a serial double-dabble conversion. Supports
// leading-zero blanking, per-digit decimal points, per-digit blink and an
// overflow (all-dash) indication. Segment outputs are active-low.
module hex_display_bank #(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  dec_mode,
  input  logic                  lz_blank,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [8*DIGITS-1:0]   segs
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(W);
  localparam int CW = $clog2(BLINK_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  // Double-dabble correction: a BCD nibble of 5 or more overflows on doubling.
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Active-low a..g glyph with DP (bit 7) off.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
  endfunction

  state_t              state_q;
  logic                busy_q;
  logic                overflow_q;
  logic                valid_q;
  logic [W-1:0]        disp_q;
  logic [W-1:0]        shift_q;
  logic [W-1:0]        bcd_q;
  logic [IW-1:0]       iter_q;
  logic                ovf_acc_q;
  logic                lz_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   bm_q;
  // Sideband captured with a decimal load, committed when its result is shown
  logic                pend_lz_q;
  logic [DIGITS-1:0]   pend_dp_q;
  logic [DIGITS-1:0]   pend_bm_q;
  logic [CW-1:0]       blink_cnt_q;
  logic                phase_q;
  logic [8*DIGITS-1:0] segs_q;
  logic [8*DIGITS-1:0] segs_d;

  logic [W-1:0]        adj;
  logic [W-1:0]        bcd_d;
  logic                shout;

  // One double-dabble step: correct every nibble, then shift in the binary MSB.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  assign bcd_d = {adj[W-2:0], shift_q[W-1]};
  assign shout = adj[W-1];

  // Control FSM: hex loads update the display directly, decimal loads run W steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      disp_q     <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_acc_q  <= 1'b0;
      lz_q       <= 1'b0;
      dp_q       <= '0;
      bm_q       <= '0;
      pend_lz_q  <= 1'b0;
      pend_dp_q  <= '0;
      pend_bm_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            if (!dec_mode) begin
              disp_q     <= value;
              overflow_q <= 1'b0;
              valid_q    <= 1'b1;
              lz_q       <= lz_blank;
              dp_q       <= dp;
              bm_q       <= blink_mask;
            end else begin
              shift_q   <= value;
              bcd_q     <= '0;
              iter_q    <= '0;
              ovf_acc_q <= 1'b0;
              pend_lz_q <= lz_blank;
              pend_dp_q <= dp;
              pend_bm_q <= blink_mask;
              state_q   <= CONV;
              busy_q    <= 1'b1;
            end
          end
        end
        CONV: begin
          bcd_q     <= bcd_d;
          shift_q   <= {shift_q[W-2:0], 1'b0};
          ovf_acc_q <= ovf_acc_q | shout;
          iter_q    <= iter_q + IW'(1);
          if (iter_q == IW'(W - 1)) begin
            disp_q     <= bcd_d;
            overflow_q <= ovf_acc_q | shout;
            valid_q    <= 1'b1;
            lz_q       <= pend_lz_q;
            dp_q       <= pend_dp_q;
            bm_q       <= pend_bm_q;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running blink timebase; phase flips each time the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

  logic       lead;
  logic [3:0] nib;
  logic [7:0] g;

  // Per-digit glyph selection, scanning from the top digit for leading zeros.
  always_comb begin
    segs_d = '1;
    lead   = lz_q & ~overflow_q;
    nib    = '0;
    g      = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_q[4*i +: 4];
      g   = glyph(nib);
      if (overflow_q) begin
        g = 8'hBF;
      end else if (lead && nib == 4'h0 && i != 0) begin
        g = 8'hFF;
      end
      if (nib != 4'h0) begin
        lead = 1'b0;
      end
      g[7] = ~dp_q[i];
      if (phase_q && bm_q[i]) begin
        g = 8'hFF;
      end
      if (!valid_q) begin
        g = 8'hFF;
      end
      segs_d[8*i +: 8] = g;
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segs_q <= '1;
    end else begin
      segs_q <= segs_d;
    end
  end

  assign segs     = segs_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank (6 digits, fast blink) with hand-computed
// expected segment patterns.
module tb_hex_display_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [23:0] value = '0;
  logic        dec_mode = 1'b0;
  logic        lz_blank = 1'b0;
  logic [5:0]  dp = '0;
  logic [5:0]  blink_mask = '0;
  logic        busy;
  logic        overflow;
  logic [47:0] segs;

  int n_vec = 0;
  int n_err = 0;

  hex_display_bank #(.DIGITS(6), .BLINK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dec_mode   (dec_mode),
    .lz_blank   (lz_blank),
    .dp         (dp),
    .blink_mask (blink_mask),
    .busy       (busy),
    .overflow   (overflow),
    .segs       (segs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step through a conversion while busy, optionally injecting a hex load at a
  // given busy cycle and checking the held display at busy cycle 12.
  task automatic run_conv(input int inj, input logic [23:0] inj_val,
                          input logic [47:0] mid_exp, output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == inj) begin
        load       = 1'b1;
        value      = inj_val;
        dec_mode   = 1'b0;
        lz_blank   = 1'b1;
        dp         = 6'h3F;
        blink_mask = 6'h3F;
      end else begin
        load = 1'b0;
      end
      if (cnt == 12) chk("held_during_conv", segs, mid_exp);
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int k;
    logic [7:0] prev;
    logic [7:0] exp0;

    // Reset state
    repeat (3) tick();
    chk("rst_segs", segs, 48'hFFFFFFFFFFFF);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_ovf", {47'd0, overflow}, 48'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_no_load", segs, 48'hFFFFFFFFFFFF);
    end

    // Hex with leading-zero blanking and a DP on digit 2
    value = 24'h00A3F0; dec_mode = 1'b0; lz_blank = 1'b1; dp = 6'b000100; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("hex_busy", {47'd0, busy}, 48'd0);
    tick();
    chk("hex_lz", segs, 48'hFFFF88308EC0);

    // Decimal 123456, with an ignored load at busy cycle 5
    value = 24'd123456; dec_mode = 1'b1; lz_blank = 1'b0; dp = '0; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("dec_busy_rise", {47'd0, busy}, 48'd1);
    run_conv(5, 24'd7, 48'hFFFF88308EC0, cnt);
    chk("dec_busy_len", 48'(cnt), 48'd24);
    chk("dec_ovf", {47'd0, overflow}, 48'd0);
    // Load one cycle after busy falls must be accepted
    value = 24'h000042; dec_mode = 1'b0; lz_blank = 1'b1; dp = '0; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("dec_result", segs, 48'hF9A4B0999282);
    tick();
    chk("load_after_busy", segs, 48'hFFFFFFFF99A4);

    // Overflow, with a load on the edge where busy falls (ignored)
    value = 24'd1000000; dec_mode = 1'b1; lz_blank = 1'b1; dp = '0; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    run_conv(24, 24'h000002, 48'hFFFFFFFF99A4, cnt);
    chk("ovf_busy_len", 48'(cnt), 48'd24);
    chk("ovf_flag", {47'd0, overflow}, 48'd1);
    tick();
    chk("ovf_dashes", segs, 48'hBFBFBFBFBFBF);
    tick();
    chk("ovf_edge_load_ignored", segs, 48'hBFBFBFBFBFBF);
    value = 24'h000001; dec_mode = 1'b0; lz_blank = 1'b1; dp = '0; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ovf_cleared", {47'd0, overflow}, 48'd0);
    tick();
    chk("hex_after_ovf", segs, 48'hFFFFFFFFFFF9);

    // Blink on digit 0 with a 4-cycle half-period
    value = 24'h000005; dec_mode = 1'b0; lz_blank = 1'b1; dp = '0; blink_mask = 6'b000001;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    prev = segs[7:0];
    k = 0;
    while (segs[7:0] == prev && k < 12) begin
      tick();
      k++;
    end
    chk("blink_toggle_seen", {47'd0, (k < 12)}, 48'd1);
    exp0 = (prev == 8'h92) ? 8'hFF : 8'h92;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        chk("blink_digit0", {40'd0, segs[7:0]}, {40'd0, exp0});
        chk("blink_others", {8'd0, segs[47:8]}, {8'd0, 40'hFFFFFFFFFF});
        tick();
      end
      exp0 = (exp0 == 8'h92) ? 8'hFF : 8'h92;
    end

    // Reset in the middle of a conversion
    value = 24'd999999; dec_mode = 1'b1; lz_blank = 1'b0; dp = '0; blink_mask = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (9) tick();
    chk("midconv_busy", {47'd0, busy}, 48'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {47'd0, busy}, 48'd0);
    chk("async_rst_segs", segs, 48'hFFFFFFFFFFFF);
    chk("async_rst_ovf", {47'd0, overflow}, 48'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_blank", segs, 48'hFFFFFFFFFFFF);
      chk("post_rst_busy", {47'd0, busy}, 48'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Multi-digit seven-segment display driver that generalises the single-digit hex decoder to `DIGITS` displays. It latches a value on a `load` strobe and shows it in hex, or in decimal after an iterative binary-to-BCD conversion. It also provides leading-zero blanking, per-digit decimal points, per-digit blinking and an overflow indication. It sits between application logic (counters, lock FSMs) and the board's HEX0..HEXn pins.

## Interface
Parameters:
- `DIGITS`, 6, number of displays; value width `W = 4*DIGITS`.
- `BLINK_DIV`, 12_500_000, clock cycles per blink half-period. Must be ≥ 2.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: single-cycle strobe; captures `value`, `dec_mode`, `lz_blank`, `dp`, `blink_mask` when `busy`=0.
- `value` input W: unsigned value to display.
- `dec_mode` input 1: 1 = decimal display, 0 = hex.
- `lz_blank` input 1: blank leading zeros.
- `dp` input DIGITS: decimal point enable per digit; 1 = lit.
- `blink_mask` input DIGITS: per-digit blink enable.
- `busy` output 1: decimal conversion in progress.
- `overflow` output 1: last decimal value was ≥ 10^DIGITS.
- `segs` output 8*DIGITS: digit i on `segs[8i+7:8i]`; digit 0 is least significant. Active-low; bit0..bit6 = a..g, bit7 = DP.

## Operation
- Glyph codes (hex): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. Blank FF. Dash BF.
- DP: bit7 is cleared when the latched `dp[i]`=1 and the digit is not blink-blanked. DP is lit even on leading-zero-blanked digits.
- Two-state control FSM: IDLE, CONV.
  - IDLE, `load`=1, `dec_mode`=0: update the display register directly, clear `overflow`, stay in IDLE.
  - IDLE, `load`=1, `dec_mode`=1: latch value into a shift register, clear the BCD accumulator, go to CONV.
  - CONV: double-dabble iteration each cycle. Add 3 to every BCD nibble ≥ 5, then shift left 1 with the binary MSB entering BCD bit 0. After W iterations, write BCD to the display register, set `overflow` if any bit shifted out of the top BCD nibble was 1, return to IDLE.
- `load` while `busy`=1 is ignored entirely, including its sideband inputs. The previous display is held during CONV.
- Leading-zero blanking: scanning from digit DIGITS-1 downward, digits equal to 0 are blanked until the first nonzero digit. Digit 0 is never blanked.
- Overflow display: all digits show dash. `lz_blank` is ignored; DP and blink still apply.
- Blink: a free-running counter counts 0..BLINK_DIV-1. A phase bit toggles on wrap. When phase=1, every digit with its latched `blink_mask` bit set outputs FF, including DP. `load` does not disturb the counter.
- Before the first completed load after reset, all digits are FF.

## Timing
- Reset values: `segs` all 1s, `busy`=0, `overflow`=0, FSM IDLE, blink counter 0, phase 0, all latched fields 0, display-valid flag 0.
- `segs` is registered from the display state.
- Hex path: `load` sampled at edge 0 → new `segs` after edge 1.
- Decimal path:
  - `busy` rises after edge 0 and stays high for exactly W cycles.
  - Iterations run on edges 1..W.
  - `busy` falls and `overflow` updates after edge W.
  - New `segs` appear after edge W+1.
- A `load` on the same edge `busy` falls is ignored. A `load` one cycle later is accepted.
- Blink phase toggles every BLINK_DIV cycles. `segs` reflects the new phase one cycle after the toggle.
- Reset asserted mid-CONV aborts immediately and asynchronously. After release, nothing is displayed until a new load.

## Test plan
- Reset: hold `rst_n`=0 → `segs`=48'hFFFFFFFFFFFF, `busy`=0, `overflow`=0. After release with no load, `segs` unchanged for 100 cycles.
- Hex with leading-zero blanking: `value`=24'h00A3F0, `lz_blank`=1, `dp`=6'b000100 → after 1 cycle, digits 5..0 = FF, FF, 88, 30, 8E, C0. `busy` stays 0.
- Decimal: `value`=24'd123456, `dec_mode`=1 → `busy` high exactly 24 cycles; digits 5..0 = F9, A4, B0, 99, 92, 82. A second `load` with 24'd7 at busy cycle 5 has no effect.
- Overflow: `value`=24'd1000000, decimal → `overflow`=1, all digits BF. Then hex load 24'h000001 → `overflow`=0, digit0 = F9.
- Blink (BLINK_DIV=4): `blink_mask`=6'b000001, hex 24'h000005 → digit0 alternates 92 for 4 cycles and FF for 4 cycles. Other digits steady.
- Reset mid-conversion: drop `rst_n` at busy cycle 10 → `busy`=0 and `segs` all 1s immediately. After release, no update appears within 30 cycles.
